// File: rtl/seq_booth_mult.sv
// Sequential signed radix-2 Booth multiplier (one Booth step per clock).
// Returns the low WIDTH bits of the product, a signed-overflow flag and a
// one-cycle ready pulse. Optional zero/one early exit is built when the
// macro SEQ_MULT_EARLY_TERM_EN is defined.
module seq_booth_mult #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_rdy,
  output logic             busy
);

  // Product register: {upper accumulator, multiplier, Booth guard bit}
  localparam int unsigned PW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;

  logic [WIDTH:0]     upper_ext;
  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     sum;
  logic [PW-1:0]      step_c;
  logic [WIDTH:0]     hi_chk;

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic               early_q, early_d;
  logic               early_hit;
  logic [WIDTH-1:0]   early_val;

  // Trivial-operand detection on the incoming operands
  always_comb begin
    early_hit = 1'b1;
    early_val = '0;
    if (operand_a == '0 || operand_b == '0) begin
      early_val = '0;
    end else if (operand_a == WIDTH'(1)) begin
      early_val = operand_b;
    end else if (operand_b == WIDTH'(1)) begin
      early_val = operand_a;
    end else begin
      early_hit = 1'b0;
    end
  end
`endif

  // One Booth step: add/sub on a WIDTH+1 bit upper field, then arithmetic shift
  always_comb begin
    upper_ext = {prod_q[PW-1], prod_q[PW-1:WIDTH+1]};
    a_ext     = {a_q[WIDTH-1], a_q};
    case (prod_q[1:0])
      2'b01:   sum = upper_ext + a_ext;
      2'b10:   sum = upper_ext - a_ext;
      default: sum = upper_ext;
    endcase
    step_c = {sum, prod_q[WIDTH:1]};
    hi_chk = step_c[2*WIDTH:WIDTH];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    a_d     = a_q;
    res_d   = res_q;
    exc_d   = exc_q;
`ifdef SEQ_MULT_EARLY_TERM_EN
    early_d = early_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (ctrl_mult) begin
          a_d     = operand_a;
          prod_d  = {WIDTH'(0), operand_b, 1'b0};
          cnt_d   = '0;
          state_d = RUN;
`ifdef SEQ_MULT_EARLY_TERM_EN
          early_d = early_hit;
          if (early_hit) begin
            a_d = early_val;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (early_q) begin
          early_d = 1'b0;
          res_d   = a_q;
          exc_d   = 1'b0;
          state_d = DONE;
        end else begin
`endif
          prod_d = step_c;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            res_d   = step_c[WIDTH:1];
            exc_d   = ~((&hi_chk) | ~(|hi_chk));
            state_d = DONE;
          end
`ifdef SEQ_MULT_EARLY_TERM_EN
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    rdy_d  = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      a_q     <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SEQ_MULT_EARLY_TERM_EN
      early_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      a_q     <= a_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
`ifdef SEQ_MULT_EARLY_TERM_EN
      early_q <= early_d;
`endif
    end
  end

  assign result     = res_q;
  assign exception  = exc_q;
  assign result_rdy = rdy_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_seq_booth_mult.sv
// Directed self-checking bench for seq_booth_mult (WIDTH=32).
module tb_seq_booth_mult;

  logic        clock;
  logic        reset;
  logic        ctrl_mult;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] result;
  logic        exception;
  logic        result_rdy;
  logic        busy;

  int n_asserts = 0;
  int n_fails   = 0;

  seq_booth_mult #(.WIDTH(32), .CNT_W(6)) dut (
    .clock      (clock),
    .reset      (reset),
    .ctrl_mult  (ctrl_mult),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .result     (result),
    .exception  (exception),
    .result_rdy (result_rdy),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
    if (a == 32'd0 || b == 32'd0 || a == 32'd1 || b == 32'd1) return 1;
`endif
    return 32;
  endfunction

  // Pulse ctrl_mult for exactly one accepted edge
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    ctrl_mult = 1'b1;
    operand_a = a;
    operand_b = b;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
  endtask

  // Count edges after the start edge until result_rdy; busy must cover the gap
  task automatic wait_rdy(input string tag, input int lat_exp);
    int lat = -1;
    logic bad_busy = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clock);
      #1;
      if (result_rdy) begin
        if (busy) bad_busy = 1'b1;
        lat = i;
        break;
      end
      if (!busy) bad_busy = 1'b1;
    end
    check({tag, " latency"}, lat, lat_exp);
    check({tag, " busy"}, 32'(bad_busy), 32'd0);
  endtask

  task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res_exp, input logic exc_exp);
    start_op(a, b);
    wait_rdy(tag, exp_lat(a, b));
    check({tag, " result"}, result, res_exp);
    check({tag, " exception"}, 32'(exception), 32'(exc_exp));
    @(posedge clock);
    #1;
    check({tag, " rdy pulse"}, 32'(result_rdy), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " result hold"}, result, res_exp);
  endtask

  initial begin
    int   lat;
    logic seen;
    reset     = 1'b1;
    ctrl_mult = 1'b0;
    operand_a = '0;
    operand_b = '0;
    #12;
    check("reset result", result, 32'd0);
    check("reset exception", 32'(exception), 32'd0);
    check("reset rdy", 32'(result_rdy), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    do_mult("7*-3", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    do_mult("min*-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    do_mult("min*1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
    do_mult("2^16*2^16", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    do_mult("ffff*2^16", 32'h0000_FFFF, 32'h0001_0000, 32'hFFFF_0000, 1'b1);
    do_mult("7fff*2^16", 32'h0000_7FFF, 32'h0001_0000, 32'h7FFF_0000, 1'b0);

    // Start request during RUN is ignored; back-to-back start in DONE is taken
    start_op(32'd5, 32'd6);
    lat = -1;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clock);
      #1;
      if (i == 9) begin
        ctrl_mult = 1'b1;
        operand_a = 32'd9;
        operand_b = 32'd9;
      end else begin
        ctrl_mult = 1'b0;
      end
      if (result_rdy) begin
        lat = i;
        break;
      end
    end
    check("5*6 latency", lat, 32'd32);
    check("5*6 result", result, 32'd30);
    check("5*6 exception", 32'(exception), 32'd0);
    ctrl_mult = 1'b1;
    operand_a = 32'hFFFF_FFFC;
    operand_b = 32'hFFFF_FFFC;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0;
    check("b2b rdy low", 32'(result_rdy), 32'd0);
    check("b2b busy", 32'(busy), 32'd1);
    wait_rdy("-4*-4", 32);
    check("-4*-4 result", result, 32'd16);
    check("-4*-4 exception", 32'(exception), 32'd0);
    @(posedge clock);
    #1;

    // Reset in the middle of RUN abandons the operation
    start_op(32'd3, 32'd3);
    repeat (14) @(posedge clock);
    #1;
    check("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid-reset result", result, 32'd0);
    check("mid-reset exception", 32'(exception), 32'd0);
    check("mid-reset rdy", 32'(result_rdy), 32'd0);
    check("mid-reset busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (result_rdy || busy) seen = 1'b1;
    end
    check("no rdy after reset", 32'(seen), 32'd0);
    do_mult("3*3", 32'd3, 32'd3, 32'd9, 1'b0);

    // Zero and one operands (early exit only when the option is built)
    do_mult("0*x", 32'd0, 32'h1234_5678, 32'd0, 1'b0);
    do_mult("1*x", 32'd1, 32'hFFFF_FF00, 32'hFFFF_FF00, 1'b0);
    do_mult("x*1", 32'hFFFF_FF00, 32'd1, 32'hFFFF_FF00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/seq_booth_mult.md
Name: seq_booth_mult

Overview:
- Sequential signed radix-2 Booth multiplier; the multiply half of the multdiv unit, complementing the divide path and its special-case detector.
- Accepts a start pulse with two 2's-complement operands and iterates one Booth step per cycle.
- Returns the low WIDTH bits of the product, a signed-overflow exception flag, and a one-cycle ready pulse.
- Consumed by the ALU/execute stage, which stalls on busy.

Parameters:
WIDTH, 32, operand and result width in bits; the full product is 2*WIDTH internally.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
ctrl_mult  input  1  start request; sampled on a rising edge only in IDLE or DONE.
operand_a  input  WIDTH  multiplicand, signed; latched on the accepted start edge.
operand_b  input  WIDTH  multiplier, signed; latched on the accepted start edge.
result  output  WIDTH  low WIDTH bits of operand_a*operand_b.
exception  output  1  high when the true product does not fit in WIDTH signed bits.
result_rdy  output  1  one-cycle pulse; result and exception are valid in this cycle.
busy  output  1  high in RUN.

Behaviour:
- Reset (async, active-high): state=IDLE; counter, product register and latched operands cleared; result=0, exception=0, result_rdy=0, busy=0. Reset mid-RUN abandons the operation; no result_rdy is produced for it.
- States: IDLE, RUN, DONE.
  - IDLE: if ctrl_mult=1 at an edge, latch operands, load product reg {WIDTH zeros, operand_b, 1'b0} (2*WIDTH+1 bits), counter=0, go to RUN.
  - RUN: each edge performs one Booth step:
    - Inspect the two LSBs: 01 -> add operand_a to the upper WIDTH bits; 10 -> subtract it; 00/11 -> no-op.
    - Then arithmetic-shift-right the whole register by 1. Use WIDTH+1-bit add/subtract on the upper half so operand_a=most-negative is handled.
    - counter++. On the step where counter reaches WIDTH-1, go to DONE and register the outputs.
  - DONE: lasts exactly one cycle.
    - result_rdy=1; result = product bits [WIDTH:1] low half.
    - exception=1 iff the upper WIDTH+1 bits of the 2*WIDTH product are not all equal (sign-extension check).
    - Next edge: if ctrl_mult=1, behave as the IDLE accept (back-to-back); else go to IDLE.
- Latency: start accepted at edge E0 -> result_rdy high from edge E_WIDTH to E_WIDTH+1 (32 cycles for WIDTH=32).
- result and exception hold their last values until the next DONE; they are not cleared on return to IDLE.
- ctrl_mult during RUN is ignored; it is not queued. Operand changes after E0 have no effect.
- busy=1 exactly in RUN; result_rdy and busy are never both high.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined:
  - At the accepted start edge, if operand_a==0 or operand_b==0, skip RUN and go straight to DONE with result=0, exception=0. result_rdy is high from E1 to E2.
  - The same early exit applies to operand_a==1 (result=operand_b) and operand_b==1 (result=operand_a), each with exception=0.
- Undefined: every operation takes the full WIDTH-cycle RUN path, including zero and one operands.

Test Plan:
- operand_a=7, operand_b=0xFFFFFFFD, 1-cycle ctrl_mult -> result_rdy pulses exactly once, 32 cycles after the start edge; result=0xFFFFFFEB, exception=0; busy=1 for the 31 cycles before.
- operand_a=0x80000000, operand_b=0xFFFFFFFF -> result=0x80000000, exception=1. Then operand_a=0x80000000, operand_b=1 -> result=0x80000000, exception=0.
- operand_a=0x00010000, operand_b=0x00010000 -> result=0x00000000, exception=1. Then 0x0000FFFF*0x00010000 -> result=0xFFFF0000, exception=1. Then 0x00007FFF*0x00010000 -> result=0x7FFF0000, exception=0.
- Start 5*6; pulse ctrl_mult with operands 9*9 at cycle 10 of RUN -> ignored, result=30. Assert ctrl_mult with operands -4*-4 in the DONE cycle -> second result_rdy 32 cycles later with result=16.
- Start 3*3; assert reset at cycle 15 for one cycle -> all outputs 0, state IDLE, no result_rdy. A new start afterwards completes normally with result=9.
- With SEQ_MULT_EARLY_TERM_EN: 0*0x12345678 -> result_rdy one cycle after start, result=0. 1*0xFFFFFF00 -> result=0xFFFFFF00. Without the macro: both take 32 cycles with the same values.
